// File: rtl/trace_pkg.sv
// Shared constants and FSM state encoding for the trace replay front end.
package trace_pkg;

  localparam int unsigned TRACE_ADDR_W     = 10;
  localparam int unsigned TRACE_DATA_W     = 32;
  localparam int unsigned TRACE_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

endpackage

// File: rtl/trace_sync_fifo.sv
// Small synchronous FIFO; the head entry is presented combinationally from storage.
module trace_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [DATA_W-1:0]        o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_wr = i_push && (!o_full || i_pop);
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/trace_fetch_ctrl.sv
// Streams a stored address trace out of the trace SRAM over a valid/ready port,
// issuing reads only while the output FIFO has room for every in-flight word.
module trace_fetch_ctrl
  import trace_pkg::*;
#(
  parameter int unsigned ADDR_W     = TRACE_ADDR_W,
  parameter int unsigned DATA_W     = TRACE_DATA_W,
  parameter int unsigned FIFO_DEPTH = TRACE_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   trace_len,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [ADDR_W-1:0] sram_addr0,
  input  logic [DATA_W-1:0] sram_dout0,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [DATA_W-1:0] addr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   fetch_count
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  trace_state_e      r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_rd_ptr;
  logic [LEN_W-1:0]  r_fetch_count;
  logic [ADDR_W-1:0] r_addr0;
  logic              r_csb0;
  logic              r_rd_pend;
  logic              r_busy;
  logic              r_done;

  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic [OCC_W-1:0]  w_occ;
  logic              w_issue;
  logic              w_last;

  trace_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_rd_pend),
    .i_push_data (sram_dout0),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_head)
  );

  assign w_pop = !w_empty && addr_ready;

  // Slots claimed next cycle: buffered words, data landing now, the read on the bus.
  assign w_occ = OCC_W'(w_fifo_count) + OCC_W'(r_rd_pend) + OCC_W'(!r_csb0)
               - OCC_W'(w_pop);

  assign w_issue = (r_state == FETCH) && (r_rd_ptr != r_len) && !w_full
                && (w_occ < OCC_W'(FIFO_DEPTH));
  assign w_last  = ((r_rd_ptr + LEN_W'(1)) == r_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_rd_ptr      <= '0;
      r_fetch_count <= '0;
      r_addr0       <= '0;
      r_csb0        <= 1'b1;
      r_rd_pend     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_csb0    <= 1'b1;
      r_rd_pend <= !r_csb0;
      if (w_pop) begin
        r_fetch_count <= r_fetch_count + LEN_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len         <= trace_len;
            r_rd_ptr      <= '0;
            r_fetch_count <= '0;
            if (trace_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (w_issue) begin
            r_csb0   <= 1'b0;
            r_addr0  <= r_rd_ptr[ADDR_W-1:0];
            r_rd_ptr <= r_rd_ptr + LEN_W'(1);
            if (w_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Final read has returned and its word has been taken by the consumer.
          if (w_empty && !r_rd_pend && r_csb0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sram_csb0   = r_csb0;
  assign sram_web0   = 1'b1;
  assign sram_addr0  = r_addr0;
  assign addr_valid  = !w_empty;
  assign addr_data   = w_head;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_trace_fetch_ctrl.sv
// Directed bench for trace_fetch_ctrl with a one-cycle-latency SRAM model and a
// per-cycle monitor of the read bus and the output handshake.
module tb_trace_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] trace_len;
  logic        sram_csb0;
  logic        sram_web0;
  logic [9:0]  sram_addr0;
  logic [31:0] sram_dout0;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr_data;
  logic        busy;
  logic        done;
  logic [10:0] fetch_count;

  logic [31:0] mem [1024];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic mon_en = 1'b0;

  int n_issued, rx, first_csb, first_valid, max_infl, last_rd;
  logic stalled_prev;
  logic [31:0] prev_data;

  trace_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .trace_len   (trace_len),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_addr0  (sram_addr0),
    .sram_dout0  (sram_dout0),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .addr_data   (addr_data),
    .busy        (busy),
    .done        (done),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Trace SRAM: read data valid the cycle after the read is issued.
  always @(posedge clk) begin
    if (!sram_csb0) sram_dout0 <= mem[sram_addr0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive ready after the edge, observe the DUT on the falling edge.
  task automatic step();
    int infl;
    @(posedge clk);
    #1;
    cyc++;
    addr_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    if (mon_en) begin
      if (!sram_csb0) begin
        chk("rd_addr", 32'(sram_addr0), 32'(n_issued));
        if (first_csb < 0) first_csb = cyc;
        last_rd = int'(sram_addr0);
        n_issued++;
      end
      if (addr_valid && first_valid < 0) first_valid = cyc;
      if (stalled_prev) begin
        chk("stall_valid", 32'(addr_valid), 32'd1);
        chk("stall_data", addr_data, prev_data);
      end
      if (addr_valid && addr_ready) begin
        chk("data", addr_data, (rx < 1024) ? mem[rx] : 32'hdeadbeef);
        rx++;
      end
      infl = n_issued - rx;
      if (infl > max_infl) max_infl = infl;
      stalled_prev = addr_valid && !addr_ready;
      prev_data    = addr_data;
    end
  endtask

  task automatic begin_run(input int len);
    n_issued = 0; rx = 0; first_csb = -1; first_valid = -1;
    max_infl = 0; last_rd = -1; stalled_prev = 1'b0; mon_en = 1'b1;
    trace_len = 11'(len);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    chk("done", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_web0", 32'(sram_web0), 32'd1);
    chk("rst_addr0", 32'(sram_addr0), 32'd0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_data", addr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
  endtask

  task automatic chk_run_end(input int len);
    chk("rx_count", 32'(rx), 32'(len));
    chk("fetch_count", 32'(fetch_count), 32'(len));
    chk("reads_issued", 32'(n_issued), 32'(len));
    chk("busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("csb_idle", 32'(sram_csb0), 32'd1);
    chk("no_extra_read", 32'(n_issued), 32'(len));
    chk("done_held", 32'(done), 32'd1);
    chk("valid_idle", 32'(addr_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; trace_len = '0; addr_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(4 * i);
    for (int i = 0; i < 3; i++) step();
    chk_reset_vals();
    reset = 1'b0;
    step();

    // Zero-length run completes at once without touching the SRAM.
    chk("pre_len0_done", 32'(done), 32'd0);
    begin_run(0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("len0_count", 32'(fetch_count), 32'd0);
    chk("len0_reads", 32'(n_issued), 32'd0);
    chk("len0_rx", 32'(rx), 32'd0);

    // Eight entries at full rate.
    ready_mode = 0;
    begin_run(8);
    chk("busy_run", 32'(busy), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    wait_done(200);
    chk("first_latency", 32'(first_valid - first_csb), 32'd2);
    chk_run_end(8);

    // Sixteen entries with a randomly stalling consumer.
    ready_mode = 1;
    begin_run(16);
    wait_done(400);
    chk("max_inflight_ok", 32'(max_infl <= 4), 32'd1);
    chk_run_end(16);
    ready_mode = 0;

    // A second start during FETCH must not disturb the run.
    begin_run(8);
    for (int i = 0; i < 3; i++) step();
    trace_len = 11'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    chk_run_end(8);

    // Reset in the middle of a 20-entry run, then a clean 3-entry run.
    begin_run(20);
    for (int i = 0; i < 100 && rx < 5; i++) step();
    chk("mid_rx_reached", 32'(rx >= 5), 32'd1);
    reset = 1'b1;
    mon_en = 1'b0;
    step();
    chk_reset_vals();
    reset = 1'b0;
    step();
    begin_run(3);
    wait_done(100);
    chk_run_end(3);

    // Full 1024-entry run across the whole address space.
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    begin_run(1024);
    wait_done(3000);
    chk("last_rd_addr", 32'(last_rd), 32'd1023);
    chk_run_end(1024);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
